// File: rtl/request_encoder.sv
// request_encoder: queues four request lines as sticky pending bits and presents one at a time as a registered 2-bit address with enable under valid/ready
module request_encoder #(
  parameter bit PRIORITY_MODE = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in0,
  input  logic       in1,
  input  logic       in2,
  input  logic       in3,
  input  logic       ready,
  output logic       addr0,
  output logic       addr1,
  output logic       enable,
  output logic [3:0] drop_count
);
  logic [3:0] pending, req, clr, rot;
  logic [1:0] last, s_fix, s_rr, p, s;
  logic       load, grant, drop;
  always_comb begin
    req = {in3, in2, in1, in0};
    load = !enable || ready;
    grant = load && |pending;
    s_fix = pending[0] ? 2'd0 : pending[1] ? 2'd1 : pending[2] ? 2'd2 : 2'd3;
    for (int k = 0; k < 4; k++) rot[k] = pending[last + 2'(k + 1)];
    p = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    s_rr = last + 2'd1 + p;
    s = PRIORITY_MODE ? s_rr : s_fix;
    clr = grant ? 4'b0001 << s : 4'b0000;
    drop = |(req & pending & ~clr);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= 4'b0000;
      enable <= 1'b0;
      {addr1, addr0} <= 2'b00;
      last <= 2'd3;
      drop_count <= 4'd0;
    end else begin
      pending <= (pending & ~clr) | req;
      if (load) enable <= |pending;
      if (grant) begin
        {addr1, addr0} <= s;
        last <= s;
      end
      if (drop && drop_count != 4'd15) drop_count <= drop_count + 4'd1;
    end
  end
endmodule

// File: tb/tb_request_encoder.sv
// tb_request_encoder: checks fixed and round-robin encoders against a queue-level model plus literal scenario expectations
module tb_request_encoder;
  logic clk = 1'b0, reset_n = 1'b0, ready = 1'b0;
  logic [3:0] req = 4'b0000;
  logic a0_0, a1_0, en_0, a0_1, a1_1, en_1;
  logic [3:0] dc_0, dc_1;
  int n_chk = 0, n_fail = 0;
  bit [3:0] m_pend [2];
  bit       m_en [2];
  int       m_addr [2], m_last [2], m_drops [2];
  always #5 clk = ~clk;
  request_encoder #(.PRIORITY_MODE(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .in0(req[0]), .in1(req[1]), .in2(req[2]), .in3(req[3]),
    .ready(ready), .addr0(a0_0), .addr1(a1_0), .enable(en_0), .drop_count(dc_0)
  );
  request_encoder #(.PRIORITY_MODE(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .in0(req[0]), .in1(req[1]), .in2(req[2]), .in3(req[3]),
    .ready(ready), .addr0(a0_1), .addr1(a1_1), .enable(en_1), .drop_count(dc_1)
  );
  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk or negedge reset_n) begin
    for (int m = 0; m < 2; m++) begin
      if (!reset_n) begin
        m_pend[m] = 4'b0000;
        m_en[m] = 1'b0;
        m_addr[m] = 0;
        m_last[m] = 3;
        m_drops[m] = 0;
      end else begin
        bit [3:0] taken;
        bit found, dup;
        taken = 4'b0000;
        if (!m_en[m] || ready) begin
          found = 1'b0;
          for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (m == 1) ? (m_last[m] + 1 + k) % 4 : k;
            if (!found && m_pend[m][idx]) begin
              found = 1'b1;
              m_addr[m] = idx;
              m_last[m] = idx;
              taken[idx] = 1'b1;
            end
          end
          m_en[m] = found;
        end
        dup = 1'b0;
        for (int i = 0; i < 4; i++) if (req[i] && m_pend[m][i] && !taken[i]) dup = 1'b1;
        m_pend[m] = (m_pend[m] & ~taken) | req;
        if (dup && m_drops[m] < 15) m_drops[m]++;
      end
    end
  end
  always @(negedge clk) begin
    check("fixed enable", int'(en_0), int'(m_en[0]));
    check("fixed addr", int'({a1_0, a0_0}), m_addr[0]);
    check("fixed drops", int'(dc_0), m_drops[0]);
    check("rr enable", int'(en_1), int'(m_en[1]));
    check("rr addr", int'({a1_1, a0_1}), m_addr[1]);
    check("rr drops", int'(dc_1), m_drops[1]);
  end
  task automatic drive(input logic [3:0] r, input logic rd);
    req = r;
    ready = rd;
    @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("reset enable", int'(en_0), 0);
    check("reset addr", int'({a1_0, a0_0}), 0);
    check("reset drops", int'(dc_0), 0);
    reset_n = 1'b1;
    drive(4'b0100, 1'b1);
    check("pulse in2 early", int'(en_0), 0);
    drive(4'b0000, 1'b1);
    check("pulse in2 enable", int'(en_0), 1);
    check("pulse in2 addr", int'({a1_0, a0_0}), 2);
    drive(4'b0000, 1'b1);
    check("pulse in2 done", int'(en_0), 0);
    drive(4'b1111, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(4'b0000, 1'b1);
      check("fixed order en", int'(en_0), 1);
      check("fixed order addr", int'({a1_0, a0_0}), i);
    end
    drive(4'b0000, 1'b1);
    check("fixed order done", int'(en_0), 0);
    drive(4'b1001, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(4'b1001, 1'b1);
      check("rr alternate", int'({a1_1, a0_1}), (i % 2 == 0) ? 3 : 0);
      check("fixed starve", int'({a1_0, a0_0}), 0);
    end
    repeat (5) drive(4'b0000, 1'b1);
    drive(4'b0010, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(4'b0000, 1'b0);
      check("bp enable", int'(en_0), 1);
      check("bp addr", int'({a1_0, a0_0}), 1);
    end
    drive(4'b0000, 1'b1);
    check("bp release", int'(en_0), 0);
    drive(4'b1011, 1'b0);
    drive(4'b0000, 1'b0);
    check("mid setup en", int'(en_0), 1);
    #2 reset_n = 1'b0;
    #1;
    check("async en", int'(en_0), 0);
    check("async addr", int'({a1_0, a0_0}), 0);
    check("async drops", int'(dc_1), 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(4'b0000, 1'b1);
      check("no stale", int'(en_0 | en_1), 0);
    end
    drive(4'b1000, 1'b0);
    drive(4'b1000, 1'b0);
    check("requeue grant", int'({a1_0, a0_0}), 3);
    check("requeue no drop", int'(dc_0), 0);
    for (int i = 1; i <= 20; i++) begin
      drive(4'b1000, 1'b0);
      check("drop sat", int'(dc_0), (i < 15) ? i : 15);
    end
    repeat (4) drive(4'b0000, 1'b1);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        #2 reset_n = 1'b0;
        #3 reset_n = 1'b1;
      end
      drive(4'($urandom) & 4'($urandom), 1'($urandom_range(0, 3) != 0));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
